// File: rtl/spike_feeder.sv
// spike_feeder: host-fed spike-vector FIFO that drives the network's
// start / sample_ready / sample / ready handshake and reports run completion.
module spike_feeder #(
    parameter int N_INPUTS = 4,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                wr_valid,
    input  logic [N_INPUTS-1:0] wr_data,
    output logic                wr_ready,
    input  logic                ready,
    input  logic                sample,
    output logic                start,
    output logic                sample_ready,
    output logic [N_INPUTS-1:0] in_spikes,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    fed_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    logic [N_INPUTS-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         cnt_q, cnt_d;
    state_t              state_q, state_d;
    logic                sample_q, ready_q;
    logic                start_q, done_q, done_d, sr_q;
    logic [N_INPUTS-1:0] spk_q, spk_d, head_d;
    logic [CNT_W-1:0]    fed_q, fed_d;
    logic                full, empty, push, pop, samp_edge, ready_rise, clr_fed;

    assign full       = (cnt_q == (AW+1)'(DEPTH));
    assign empty      = (cnt_q == '0);
    assign push       = wr_valid & ~full;
    assign samp_edge  = sample & ~sample_q;
    assign ready_rise = ready & ~ready_q;
    assign pop        = samp_edge & ~empty & (state_q == S_RUN);

    assign wr_ready     = ~full;
    assign start        = start_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign sample_ready = sr_q;
    assign in_spikes    = spk_q;
    assign fed_count    = fed_q;

    // FIFO bookkeeping and the post-update head vector. A write landing on the
    // slot that becomes the head is not in mem_q yet, so it is bypassed.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        head_d   = (push && (wr_ptr_q == rd_ptr_d)) ? wr_data : mem_q[rd_ptr_d];
        spk_d    = (cnt_d == '0) ? '0 : head_d;
    end

    // Run FSM: launch from IDLE, feed in RUN, wait for the network's final
    // ready rising edge in DRAIN; a new write during DRAIN resumes feeding.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        clr_fed = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && ready && !empty) begin
                    state_d = S_RUN;
                    clr_fed = 1'b1;
                end
            end
            S_RUN: begin
                if (pop && !push && cnt_q == (AW+1)'(1)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (push) begin
                    state_d = S_RUN;
                end else if (ready_rise) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Consumed-vector counter: cleared at launch, saturating increment per pop.
    always_comb begin
        fed_d = fed_q;
        if (clr_fed)                fed_d = '0;
        else if (pop && !(&fed_q))  fed_d = fed_q + 1'b1;
    end

    // FIFO storage; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    // Control state, edge detectors and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
            sample_q <= 1'b0;
            ready_q  <= 1'b0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            sr_q     <= 1'b0;
            spk_q    <= '0;
            fed_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            sample_q <= sample;
            ready_q  <= ready;
            start_q  <= (state_d != S_IDLE);
            done_q   <= done_d;
            sr_q     <= (cnt_d != '0);
            spk_q    <= spk_d;
            fed_q    <= fed_d;
        end
    end

endmodule

// File: tb/tb_spike_feeder.sv
// Bench for spike_feeder: directed scenarios plus a randomized run checked
// against a queue-based reference model of the feeder's rules.
module tb_spike_feeder;

    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n, enable, wr_valid, ready, sample;
    logic [N-1:0]  wr_data;
    logic          wr_ready, start, sample_ready, busy, done;
    logic [N-1:0]  in_spikes;
    logic [CW-1:0] fed_count;

    int nvec = 0;
    int nerr = 0;

    spike_feeder #(.N_INPUTS(N), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_ready(wr_ready), .ready(ready), .sample(sample),
        .start(start), .sample_ready(sample_ready), .in_spikes(in_spikes),
        .busy(busy), .done(done), .fed_count(fed_count)
    );

    always #5 clk = ~clk;

    // Reference model: 0 = idle, 1 = feeding, 2 = draining.
    logic [N-1:0] mq [$];
    int           mst;
    bit           psamp, prdy, mdone;
    int           mfed;

    task automatic model_reset();
        mq.delete();
        mst = 0; psamp = 0; prdy = 0; mdone = 0; mfed = 0;
    endtask

    task automatic model_step();
        bit push, pop, rise;
        int nst;
        push  = wr_valid && (mq.size() < DEPTH);
        pop   = sample && !psamp && (mq.size() > 0) && (mst == 1);
        rise  = ready && !prdy;
        nst   = mst;
        mdone = 0;
        if (mst == 0 && enable && ready && mq.size() > 0) begin
            nst = 1; mfed = 0;
        end else if (mst == 1 && pop && !push && mq.size() == 1) begin
            nst = 2;
        end else if (mst == 2) begin
            if (push) nst = 1;
            else if (rise) begin nst = 0; mdone = 1; end
        end
        if (pop && mfed != (1 << CW) - 1) mfed++;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(wr_data);
        psamp = sample;
        prdy  = ready;
        mst   = nst;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
    endtask

    task automatic write_vec(input logic [N-1:0] v);
        wr_valid = 1; wr_data = v;
        tick();
        wr_valid = 0;
    endtask

    task automatic pulse_sample();
        sample = 1; tick();
        sample = 0;
    endtask

    task automatic launch();
        enable = 1; ready = 1;
        for (int i = 0; i < 4 && !start; i++) tick();
        nvec++;
        if (start !== 1'b1) begin
            nerr++; $display("FAIL launch: start=%b required 1", start);
        end
    endtask

    task automatic finish_run();
        ready = 0; tick();
        ready = 1; tick();
        tick();
        enable = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; enable = 0; wr_valid = 0; wr_data = 0; ready = 0; sample = 0;
        tick(); tick();
        nvec++; if (start !== 0)        begin nerr++; $display("FAIL reset_start: got %b need 0", start); end
        nvec++; if (sample_ready !== 0) begin nerr++; $display("FAIL reset_sr: got %b need 0", sample_ready); end
        nvec++; if (in_spikes !== 0)    begin nerr++; $display("FAIL reset_spk: got %h need 0", in_spikes); end
        nvec++; if (wr_ready !== 1)     begin nerr++; $display("FAIL reset_wr_ready: got %b need 1", wr_ready); end
        nvec++; if (busy !== 0 || done !== 0 || fed_count !== 0) begin
            nerr++; $display("FAIL reset_misc: busy=%b done=%b fed=%0d need 0/0/0", busy, done, fed_count);
        end
        rst_n = 1; tick();
    endtask

    task automatic test_basic();
        logic [N-1:0] exp [4];
        exp[0] = 4'hE; exp[1] = 4'hD; exp[2] = 4'hC; exp[3] = 4'h0;
        enable = 0; ready = 1;
        write_vec(4'hF); write_vec(4'hE); write_vec(4'hD); write_vec(4'hC);
        launch();
        nvec++; if (in_spikes !== 4'hF) begin nerr++; $display("FAIL basic_head: got %h need f", in_spikes); end
        for (int i = 0; i < 4; i++) begin
            pulse_sample();
            nvec++;
            if (in_spikes !== exp[i]) begin
                nerr++; $display("FAIL basic_pop%0d: got %h need %h", i, in_spikes, exp[i]);
            end
            tick();
        end
        nvec++; if (sample_ready !== 0) begin nerr++; $display("FAIL basic_sr: got %b need 0", sample_ready); end
        nvec++; if (fed_count !== 4)    begin nerr++; $display("FAIL basic_fed: got %0d need 4", fed_count); end
        nvec++; if (busy !== 1 || start !== 1) begin
            nerr++; $display("FAIL basic_drain: busy=%b start=%b need 1/1", busy, start);
        end
        ready = 0; tick();
        ready = 1; tick();
        nvec++; if (done !== 1 || start !== 0 || busy !== 0) begin
            nerr++; $display("FAIL basic_done: done=%b start=%b busy=%b need 1/0/0", done, start, busy);
        end
        tick();
        nvec++; if (done !== 0) begin nerr++; $display("FAIL basic_done_pulse: got %b need 0", done); end
        enable = 0;
    endtask

    task automatic test_full();
        enable = 0;
        for (int i = 0; i < 9; i++) begin
            write_vec(4'(i));
            if (i >= 7) begin
                nvec++;
                if (wr_ready !== 0) begin nerr++; $display("FAIL full_wr_ready%0d: got %b need 0", i, wr_ready); end
            end
        end
        launch();
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if (in_spikes !== 4'(i)) begin nerr++; $display("FAIL full_order%0d: got %h need %h", i, in_spikes, 4'(i)); end
            pulse_sample(); tick();
        end
        nvec++; if (sample_ready !== 0) begin nerr++; $display("FAIL full_dropped: sr=%b need 0", sample_ready); end
        finish_run();
    endtask

    task automatic test_pushpop();
        logic [N-1:0] exp [4];
        exp[0] = 4'h2; exp[1] = 4'h3; exp[2] = 4'hA; exp[3] = 4'h0;
        enable = 0;
        write_vec(4'h1); write_vec(4'h2); write_vec(4'h3);
        launch();
        wr_valid = 1; wr_data = 4'hA; sample = 1;
        tick();
        wr_valid = 0; sample = 0;
        nvec++; if (in_spikes !== exp[0]) begin nerr++; $display("FAIL pp_head: got %h need 2", in_spikes); end
        tick();
        for (int i = 1; i < 4; i++) begin
            pulse_sample();
            nvec++;
            if (in_spikes !== exp[i]) begin nerr++; $display("FAIL pp_pop%0d: got %h need %h", i, in_spikes, exp[i]); end
            tick();
        end
        finish_run();
    endtask

    task automatic test_held();
        enable = 0;
        write_vec(4'h6); write_vec(4'h9);
        launch();
        sample = 1;
        repeat (5) tick();
        sample = 0; tick();
        nvec++; if (fed_count !== 1)    begin nerr++; $display("FAIL held_fed: got %0d need 1", fed_count); end
        nvec++; if (in_spikes !== 4'h9) begin nerr++; $display("FAIL held_head: got %h need 9", in_spikes); end
        pulse_sample(); tick();
        finish_run();
    endtask

    task automatic test_extend();
        enable = 0;
        write_vec(4'h3);
        launch();
        pulse_sample(); tick();
        nvec++; if (busy !== 1 || sample_ready !== 0) begin
            nerr++; $display("FAIL ext_drain: busy=%b sr=%b need 1/0", busy, sample_ready);
        end
        ready = 0;
        write_vec(4'h5);
        ready = 1;
        nvec++; if (sample_ready !== 1 || in_spikes !== 4'h5) begin
            nerr++; $display("FAIL ext_resume: sr=%b spk=%h need 1/5", sample_ready, in_spikes);
        end
        tick();
        nvec++; if (done !== 0 || start !== 1) begin
            nerr++; $display("FAIL ext_nodone: done=%b start=%b need 0/1", done, start);
        end
        pulse_sample(); tick();
        nvec++; if (fed_count !== 2) begin nerr++; $display("FAIL ext_fed: got %0d need 2", fed_count); end
        finish_run();
    endtask

    task automatic test_reset_midrun();
        enable = 0;
        write_vec(4'h7); write_vec(4'h8); write_vec(4'h9);
        launch();
        rst_n = 0; #1;
        nvec++; if (start !== 0 || busy !== 0 || sample_ready !== 0 || in_spikes !== 0 || fed_count !== 0 || wr_ready !== 1) begin
            nerr++; $display("FAIL midrst_async: start=%b busy=%b sr=%b spk=%h fed=%0d wr_ready=%b need 0/0/0/0/0/1",
                             start, busy, sample_ready, in_spikes, fed_count, wr_ready);
        end
        tick();
        rst_n = 1; enable = 1; ready = 1;
        repeat (3) tick();
        nvec++; if (start !== 0 || sample_ready !== 0) begin
            nerr++; $display("FAIL midrst_empty: start=%b sr=%b need 0/0", start, sample_ready);
        end
        enable = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            wr_valid = ($urandom_range(0, 99) < 35);
            wr_data  = 4'($urandom);
            sample   = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 99) < 25) ready = ~ready;
            if ($urandom_range(0, 99) < 10) enable = ~enable;
            tick();
            nvec++;
            if (start !== (mst != 0) || busy !== (mst != 0)) begin
                nerr++; $display("FAIL rand_state c%0d: start=%b busy=%b model_state=%0d", c, start, busy, mst);
            end
            nvec++;
            if (done !== mdone) begin nerr++; $display("FAIL rand_done c%0d: got %b need %b", c, done, mdone); end
            nvec++;
            if (sample_ready !== (mq.size() > 0) || wr_ready !== (mq.size() < DEPTH)) begin
                nerr++; $display("FAIL rand_flags c%0d: sr=%b wr_ready=%b occupancy=%0d", c, sample_ready, wr_ready, mq.size());
            end
            nvec++;
            if (in_spikes !== ((mq.size() > 0) ? mq[0] : 4'h0)) begin
                nerr++; $display("FAIL rand_spk c%0d: got %h need %h", c, in_spikes, (mq.size() > 0) ? mq[0] : 4'h0);
            end
            nvec++;
            if (fed_count !== CW'(mfed)) begin nerr++; $display("FAIL rand_fed c%0d: got %0d need %0d", c, fed_count, mfed); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_full();
        test_pushpop();
        test_held();
        test_extend();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
